// File: rtl/channel_cmd_responder.sv
// Channel-side command responder: parses 3-word command packets from the link
// and answers with a burst read, status word or error word.
module channel_cmd_responder #(
  parameter logic [3:0] CHAN_ID    = 4'd0,
  parameter int         BURST_LEN  = 8,
  parameter int         ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_last,
  output logic                  rx_ready,
  output logic [31:0]           tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [31:0]           mem_rd_data,
  output logic                  busy,
  output logic [15:0]           err_count
);

  typedef enum logic [3:0] {
    IDLE, GET_CODE, GET_ARG, DRAIN,
    SEND_CSN, SEND_CODE, FETCH, LOAD, SEND_DATA, SEND_STATUS
  } state_t;

  localparam logic [31:0] CODE_READ   = 32'h0000_0001;
  localparam logic [31:0] CODE_STATUS = 32'h0000_0002;
  localparam logic [8:0]  BURST_INIT  = 9'(BURST_LEN);

  state_t                state;
  logic [31:0]           csn;
  logic [31:0]           code;
  logic [ADDR_WIDTH-1:0] arg;
  logic [ADDR_WIDTH-1:0] addr;
  logic [8:0]            remaining;
  logic                  rx_fire;
  logic                  tx_fire;
  logic [15:0]           err_inc;
  logic                  code_known;

  assign rx_ready   = (state == IDLE) || (state == GET_CODE) ||
                      (state == GET_ARG) || (state == DRAIN);
  assign tx_valid   = (state == SEND_CSN) || (state == SEND_CODE) ||
                      (state == SEND_DATA) || (state == SEND_STATUS);
  assign busy       = (state != IDLE);
  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign err_inc    = (&err_count) ? err_count : err_count + 16'd1;
  assign code_known = (code == CODE_READ) || (code == CODE_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      csn       <= '0;
      code      <= '0;
      arg       <= '0;
      addr      <= '0;
      remaining <= '0;
      tx_data   <= '0;
      tx_last   <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (rx_fire) begin
          csn <= rx_data;
          if (rx_last) err_count <= err_inc;
          else         state     <= GET_CODE;
        end
        GET_CODE: if (rx_fire) begin
          code <= rx_data;
          if (rx_last) begin
            err_count <= err_inc;
            state     <= IDLE;
          end else begin
            state <= GET_ARG;
          end
        end
        GET_ARG: if (rx_fire) begin
          arg <= rx_data[ADDR_WIDTH-1:0];
          if (!rx_last) begin
            err_count <= err_inc;
            state     <= DRAIN;
          end else begin
            tx_data <= csn;
            tx_last <= 1'b0;
            state   <= SEND_CSN;
          end
        end
        DRAIN: if (rx_fire && rx_last) state <= IDLE;
        SEND_CSN: if (tx_fire) begin
          // Unknown codes are answered with the error flag set and end the packet.
          tx_data <= code_known ? code : (code | 32'h8000_0000);
          tx_last <= !code_known;
          state   <= SEND_CODE;
        end
        SEND_CODE: if (tx_fire) begin
          if (code == CODE_READ) begin
            addr      <= arg;
            remaining <= BURST_INIT;
            mem_addr  <= arg;
            mem_rd_en <= 1'b1;
            state     <= FETCH;
          end else if (code == CODE_STATUS) begin
            tx_data <= {CHAN_ID, 12'h000, err_count};
            tx_last <= 1'b1;
            state   <= SEND_STATUS;
          end else begin
            tx_last <= 1'b0;
            state   <= IDLE;
          end
        end
        FETCH: begin
          mem_rd_en <= 1'b0;
          state     <= LOAD;
        end
        LOAD: begin
          tx_data <= mem_rd_data;
          tx_last <= (remaining == 9'd1);
          state   <= SEND_DATA;
        end
        SEND_DATA: if (tx_fire) begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 9'd1;
          if (tx_last) begin
            tx_last <= 1'b0;
            state   <= IDLE;
          end else begin
            mem_addr  <= addr + 1'b1;
            mem_rd_en <= 1'b1;
            state     <= FETCH;
          end
        end
        SEND_STATUS: if (tx_fire) begin
          tx_last <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_cmd_responder.sv
// Scoreboard bench for channel_cmd_responder: expected TX words and buffer
// addresses are queued when a command is driven and popped as the DUT emits them.
module tb_channel_cmd_responder;
  localparam int AW = 12;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_last = 1'b0;
  logic          rx_ready;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [31:0]   mem_rd_data = '0;
  logic          busy;
  logic [15:0]   err_count;

  int tests_run = 0;
  int tests_failed = 0;
  logic [32:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit  rand_mode = 1'b0;
  int  send_cycles = 0;
  int  bp_err = 0;
  int  stab_err = 0;
  int  popped = 0;
  bit  held = 1'b0;
  logic [32:0] held_word;

  channel_cmd_responder #(.CHAN_ID(4'd3), .BURST_LEN(BL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Waveform buffer model: buffer[i] = 0xA0000000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 32'hA000_0000 + 32'(mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor, sampled mid-cycle so values are those seen at the next edge.
  initial begin
    logic [32:0]   w;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_rd_en) begin
          if (addr_q.size() == 0) check("mem_unexpected", addr_q.size(), 1);
          else begin
            a = addr_q.pop_front();
            check("mem_addr", mem_addr, a);
          end
        end
        if (held && tx_valid && {tx_last, tx_data} !== held_word) stab_err++;
        held = tx_valid && !tx_ready;
        held_word = {tx_last, tx_data};
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) check("tx_unexpected", exp_q.size(), 1);
          else begin
            w = exp_q.pop_front();
            check("tx_word", {tx_last, tx_data}, w);
            popped++;
            $display("[TB] tx %08h last=%0b", tx_data, tx_last);
          end
        end
        if (busy && !rx_ready) send_cycles++;
        if (tx_valid && rx_ready) bp_err++;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    int n = 0;
    rx_data = d;
    rx_last = l;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check("rx_timeout", n, 0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_last = 1'b0;
  endtask

  task automatic push_burst(input logic [31:0] csn, input logic [AW-1:0] arg);
    logic [AW-1:0] a;
    exp_q.push_back({1'b0, csn});
    exp_q.push_back({1'b0, 32'h1});
    for (int i = 0; i < BL; i++) begin
      a = arg + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back({(i == BL - 1), 32'hA000_0000 + 32'(a)});
    end
  endtask

  task automatic send_cmd(input logic [31:0] csn, input logic [31:0] code, input logic [31:0] arg);
    send_word(csn, 1'b0);
    send_word(code, 1'b0);
    send_word(arg, 1'b1);
    check("latency_tx_valid", tx_valid, 1);
    $display("[TB] cmd csn=%08h code=%08h arg=%08h", csn, code, arg);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst with the response cycle budget measured.
    send_cycles = 0;
    push_burst(32'hBAADF00D, 12'h010);
    send_cmd(32'hBAADF00D, 32'h1, 32'h10);
    wait_done();
    check("burst_cycles", send_cycles, 2 + 3 * BL);

    // Address wrap.
    push_burst(32'h1111_2222, 12'hFFE);
    send_cmd(32'h1111_2222, 32'h1, 32'hFFE);
    wait_done();
    check("wrap_addr_left", addr_q.size(), 0);

    // Malformed: single word with last, then 4-word packet.
    send_word(32'h5555_0001, 1'b1);
    $display("[TB] malformed 1-word");
    check("err_after_1word", err_count, 1);
    send_word(32'h5555_0002, 1'b0);
    send_word(32'h1, 1'b0);
    send_word(32'h20, 1'b0);
    send_word(32'h5555_0003, 1'b1);
    $display("[TB] malformed 4-word");
    check("err_after_4word", err_count, 2);
    check("malformed_busy", busy, 0);

    // Status reflects channel id and error count.
    exp_q.push_back({1'b0, 32'hC0DE_0001});
    exp_q.push_back({1'b0, 32'h2});
    exp_q.push_back({1'b1, 32'h3000_0002});
    send_cmd(32'hC0DE_0001, 32'h2, 32'h0);
    wait_done();

    // Unknown code.
    exp_q.push_back({1'b0, 32'hC0DE_0002});
    exp_q.push_back({1'b1, 32'h8000_0007});
    send_cmd(32'hC0DE_0002, 32'h7, 32'h0);
    wait_done();

    // Random back-pressure with a second command queued behind the first.
    rand_mode = 1'b1;
    bp_err = 0;
    stab_err = 0;
    push_burst(32'hD00D_0001, 12'h123);
    send_cmd(32'hD00D_0001, 32'h1, 32'h123);
    push_burst(32'hD00D_0002, 12'h7FC);
    send_cmd(32'hD00D_0002, 32'h1, 32'h7FC);
    wait_done();
    rand_mode = 1'b0;
    check("rx_ready_during_tx", bp_err, 0);
    check("tx_hold_stable", stab_err, 0);

    // Asynchronous reset mid-burst.
    push_burst(32'hE000_0001, 12'h200);
    send_cmd(32'hE000_0001, 32'h1, 32'h200);
    popped = 0;
    for (int n = 0; n < 200 && popped < 5; n++) @(posedge clk);
    check("pre_reset_progress", popped >= 5, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_rd_en", mem_rd_en, 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_err", err_count, 0);
    $display("[TB] reset mid-burst");
    exp_q.push_back({1'b0, 32'hE000_0002});
    exp_q.push_back({1'b0, 32'h2});
    exp_q.push_back({1'b1, 32'h3000_0000});
    send_cmd(32'hE000_0002, 32'h2, 32'h0);
    wait_done();
    push_burst(32'hE000_0003, 12'h040);
    send_cmd(32'hE000_0003, 32'h1, 32'h40);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/channel_cmd_responder.md
# channel_cmd_responder

Channel-side endpoint of the command/response link driven by the DAQ data transfer manager. It accepts 3-word command packets (serial number, command code, argument with last) on the channel RX stream and decodes the command code. It answers on the channel TX stream with a last-terminated response packet: a burst read from the channel waveform buffer, a status word, or an error word. One instance sits in each channel FPGA, between the inter-FPGA link FIFOs and the waveform buffer read port.

## Interface
- `CHAN_ID`, default 0: 4-bit channel identifier returned in the status word.
- `BURST_LEN`, default 8: number of buffer words per READ_BURST response. Range 1..256.
- `ADDR_WIDTH`, default 12: waveform buffer address width.

- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 32: command word from the link.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_last` in 1: marks the final word of a command packet.
- `rx_ready` out 1: responder accepts the current `rx_data`.
- `tx_data` out 32: response word.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_last` out 1: marks the final word of a response packet.
- `tx_ready` in 1: link accepts the current `tx_data`.
- `mem_addr` out ADDR_WIDTH: buffer read address.
- `mem_rd_en` out 1: buffer read strobe. Read data appears on `mem_rd_data` exactly 1 cycle later.
- `mem_rd_data` in 32: buffer read data.
- `busy` out 1: high in every state except IDLE.
- `err_count` out 16: count of malformed packets. Saturates at 0xFFFF.

## Operation
- A word transfers on RX when `rx_valid & rx_ready`. A word transfers on TX when `tx_valid & tx_ready`.
- States:
  - IDLE, GET_CODE, GET_ARG, DRAIN: `rx_ready=1`.
  - SEND_CSN, SEND_CODE, FETCH, LOAD, SEND_DATA, SEND_STATUS: `rx_ready=0`.
- IDLE: on RX transfer, capture `csn`.
  - If `rx_last=1`, the packet is malformed: increment `err_count` and stay in IDLE.
  - Otherwise go to GET_CODE.
- GET_CODE: on RX transfer, capture `code`.
  - If `rx_last=1`, malformed: increment `err_count` and go to IDLE.
  - Otherwise go to GET_ARG.
- GET_ARG: on RX transfer, capture `arg`.
  - If `rx_last=0`, malformed: increment `err_count` and go to DRAIN.
  - Otherwise go to SEND_CSN.
- DRAIN: discard words; on an RX transfer with `rx_last=1`, go to IDLE. A malformed packet produces no response.
- SEND_CSN: present `tx_data=csn`, `tx_last=0`. On TX transfer, go to SEND_CODE.
- SEND_CODE: present `tx_data=code`.
  - code 0x00000001 (READ_BURST): `tx_last=0`. On TX transfer, load `addr=arg[ADDR_WIDTH-1:0]`, `remaining=BURST_LEN`, and go to FETCH.
  - code 0x00000002 (STATUS): `tx_last=0`. On TX transfer, go to SEND_STATUS.
  - Any other code: present `tx_data=code|0x80000000` with `tx_last=1`. On TX transfer, go to IDLE.
- FETCH: `mem_rd_en=1` with `mem_addr=addr` for exactly one cycle, then go to LOAD.
- LOAD: register `mem_rd_data` into `tx_data`. Set `tx_last=(remaining==1)` and go to SEND_DATA.
- SEND_DATA: hold `tx_data` and `tx_last`. On TX transfer:
  - `addr` increments modulo 2^ADDR_WIDTH (wraps from max to 0).
  - `remaining` decrements.
  - If `tx_last`, go to IDLE; otherwise go to FETCH.
- SEND_STATUS: present `tx_data={CHAN_ID[3:0], 12'h000, err_count}`, `tx_last=1`. On TX transfer, go to IDLE.
- Registered datapath: `tx_data`, `tx_last`, `mem_addr` and `mem_rd_en` are flops. `tx_valid`, `rx_ready` and `busy` are decoded from state.

## Timing
- Reset values: state IDLE, `rx_ready=1`, `tx_valid=0`, `tx_last=0`, `tx_data=0`, `mem_rd_en=0`, `mem_addr=0`, `busy=0`, `err_count=0`, `csn`/`code`/`arg`=0.
- Command to response latency: the GET_ARG transfer at cycle N puts SEND_CSN with `tx_valid=1` at cycle N+1.
- With `tx_ready` held high:
  - Header: 1 cycle per word.
  - Burst data: 3 cycles per word (FETCH, LOAD, SEND_DATA).
  - A full READ_BURST response takes 2+3·BURST_LEN cycles from SEND_CSN.
- `tx_valid` stays high, and `tx_data`/`tx_last` stay stable, until accepted. No combinational path from `tx_ready` to `tx_data`.
- New commands arriving during a response are back-pressured (`rx_ready=0`), never dropped.
- Async reset mid-response forces IDLE immediately. `tx_valid` drops in the same cycle and the partial packet is not completed.
- `err_count` increment and the following command's capture may occur on consecutive cycles. Each malformed packet counts exactly once.

## Test plan
- READ_BURST, BURST_LEN=8, buffer[i]=0xA0000000+i; send {0xBAADF00D, 0x1, 0x10 last} -> TX words 0xBAADF00D, 0x1, 0xA0000010…0xA0000017, `tx_last` only on 0xA0000017, addresses 0x10..0x17.
- Address wrap: READ_BURST arg 0xFFE, ADDR_WIDTH=12 -> reads 0xFFE, 0xFFF, 0x000…0x005.
- STATUS with CHAN_ID=3 after two malformed packets -> TX {csn, 0x2, 0x30000002 last}.
- Unknown code 0x7 -> TX {csn, 0x80000007 last}, then return to IDLE (`busy=0`).
- Malformed: 4-word packet with last on word 4 -> no TX activity, `err_count` +1, next valid command answered normally; 1-word packet with last -> `err_count` +1.
- Back-pressure: toggle `tx_ready` randomly during READ_BURST -> identical word sequence, no duplicates/drops, `rx_ready=0` throughout; assert `rst_n` low mid-burst -> `tx_valid=0` in the same cycle, `busy=0`, next command served from a clean start.
